// File: rtl/mips_pkg.sv
// Shared constants and record types for the MIPS hazard controller:
// forwarding-select codes, stall FSM encoding and shadow-stage fields.
package mips_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  localparam int NUM_SHADOW = 3;  // EX, MEM, WB
  localparam int SH_EX  = 0;
  localparam int SH_MEM = 1;
  localparam int SH_WB  = 2;

  typedef struct packed {
    logic regwrite;
    logic memread;
  } stage_ctl_t;

  typedef struct packed {
    logic use_rs;
    logic use_rt;
  } src_use_t;

  // MEM has priority: it holds the younger result.
  function automatic logic [1:0] fwd_pick(input logic mem_hit, input logic wb_hit);
    if (mem_hit)     return FWD_MEM;
    else if (wb_hit) return FWD_WB;
    else             return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// Shadow copy of the EX/MEM/WB destination and write-enable fields,
// with a bubble inserted into EX whenever ID/EX is flushed.
module hazard_shadow_pipe
  import mips_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              idex_flush,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  stage_ctl_t        id_ctl,
  input  src_use_t          id_use,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output src_use_t          ex_use,
  output logic [REG_AW-1:0] ex_dst,
  output stage_ctl_t        ex_ctl,
  output logic [REG_AW-1:0] mem_dst,
  output stage_ctl_t        mem_ctl,
  output logic [REG_AW-1:0] wb_dst,
  output stage_ctl_t        wb_ctl
);

  logic [REG_AW-1:0] dst_reg [NUM_SHADOW];
  stage_ctl_t        ctl_reg [NUM_SHADOW];
  logic [REG_AW-1:0] ex_rs_reg;
  logic [REG_AW-1:0] ex_rt_reg;
  src_use_t          ex_use_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SHADOW; i++) begin
        dst_reg[i] <= '0;
        ctl_reg[i] <= '0;
      end
      ex_rs_reg  <= '0;
      ex_rt_reg  <= '0;
      ex_use_reg <= '0;
    end else begin
      if (idex_flush) begin
        dst_reg[SH_EX] <= '0;
        ctl_reg[SH_EX] <= '0;
        ex_rs_reg      <= '0;
        ex_rt_reg      <= '0;
        ex_use_reg     <= '0;
      end else begin
        dst_reg[SH_EX] <= id_dst;
        ctl_reg[SH_EX] <= id_ctl;
        ex_rs_reg      <= id_rs;
        ex_rt_reg      <= id_rt;
        ex_use_reg     <= id_use;
      end
      for (int i = 1; i < NUM_SHADOW; i++) begin
        dst_reg[i] <= dst_reg[i-1];
        ctl_reg[i] <= ctl_reg[i-1];
      end
    end
  end

  assign ex_rs   = ex_rs_reg;
  assign ex_rt   = ex_rt_reg;
  assign ex_use  = ex_use_reg;
  assign ex_dst  = dst_reg[SH_EX];
  assign ex_ctl  = ctl_reg[SH_EX];
  assign mem_dst = dst_reg[SH_MEM];
  assign mem_ctl = ctl_reg[SH_MEM];
  assign wb_dst  = dst_reg[SH_WB];
  assign wb_ctl  = ctl_reg[SH_WB];

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller beside decode: stall FSM for load-use / JR dependencies,
// control-transfer flushes, and EX / JR-target forwarding selects.
module hazard_unit
  import mips_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int FWD_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_j,
  input  logic              id_jr,
  input  logic              ex_branch_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic [FWD_W-1:0]  fwd_a,
  output logic [FWD_W-1:0]  fwd_b,
  output logic [FWD_W-1:0]  fwd_jr
);

  stage_ctl_t        id_ctl;
  src_use_t          id_use;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
  src_use_t          ex_use;
  stage_ctl_t        ex_ctl, mem_ctl, wb_ctl;

  logic [0:0] state_reg, state_next;
  logic [1:0] cnt_reg, cnt_next;
  logic [1:0] stall_n;

  assign id_ctl.regwrite = id_regwrite;
  assign id_ctl.memread  = id_memread;
  assign id_use.use_rs   = id_use_rs;
  assign id_use.use_rt   = id_use_rt;

  hazard_shadow_pipe #(
    .REG_AW(REG_AW)
  ) u_shadow (
    .clk       (clk),
    .reset     (reset),
    .idex_flush(idex_flush),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_dst    (id_dst),
    .id_ctl    (id_ctl),
    .id_use    (id_use),
    .ex_rs     (ex_rs),
    .ex_rt     (ex_rt),
    .ex_use    (ex_use),
    .ex_dst    (ex_dst),
    .ex_ctl    (ex_ctl),
    .mem_dst   (mem_dst),
    .mem_ctl   (mem_ctl),
    .wb_dst    (wb_dst),
    .wb_ctl    (wb_ctl)
  );

  // Use flags and the WB load bit ride along in the shadow but steer nothing here.
  logic [2:0] unused_bits;
  assign unused_bits = {ex_use, wb_ctl.memread};

  // Slot 0/1 = EX operands A/B, slot 2 = JR target read in ID.
  logic [REG_AW-1:0] fwd_src [3];
  logic [1:0]        fwd_sel [3];

  assign fwd_src[0] = ex_rs;
  assign fwd_src[1] = ex_rt;
  assign fwd_src[2] = id_rs;

  for (genvar gi = 0; gi < 3; gi++) begin : g_fwd
    logic mem_hit, wb_hit;
    assign mem_hit = mem_ctl.regwrite && !mem_ctl.memread &&
                     (mem_dst != '0) && (mem_dst == fwd_src[gi]);
    assign wb_hit  = wb_ctl.regwrite && (wb_dst != '0) && (wb_dst == fwd_src[gi]);
    assign fwd_sel[gi] = fwd_pick(mem_hit, wb_hit);
  end

  assign fwd_a  = FWD_W'(fwd_sel[0]);
  assign fwd_b  = FWD_W'(fwd_sel[1]);
  assign fwd_jr = FWD_W'(fwd_sel[2]);

  logic ex_writes_rs, mem_load_rs, ex_load_use;

  assign ex_writes_rs = ex_ctl.regwrite && (ex_dst != '0) && (ex_dst == id_rs);
  assign mem_load_rs  = mem_ctl.regwrite && mem_ctl.memread &&
                        (mem_dst != '0) && (mem_dst == id_rs);
  assign ex_load_use  = ex_ctl.regwrite && ex_ctl.memread && (ex_dst != '0) &&
                        ((id_use_rs && (id_rs == ex_dst)) || (id_use_rt && (id_rt == ex_dst)));

  // JR resolves its target in ID, so it waits for results ALU forwarding would cover.
  always_comb begin
    stall_n = 2'd0;
    if (id_jr && ex_writes_rs)     stall_n = ex_ctl.memread ? 2'd2 : 2'd1;
    else if (id_jr && mem_load_rs) stall_n = 2'd1;
    else if (ex_load_use)          stall_n = 2'd1;
  end

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_RUN: begin
        if (stall_n != 2'd0) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          cnt_next   = stall_n - 2'd1;
          state_next = (stall_n - 2'd1 != 2'd0) ? ST_STALL : ST_RUN;
        end else if (id_j || id_jr) begin
          ifid_flush = 1'b1;
        end
      end
      ST_STALL: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
        cnt_next   = cnt_reg - 2'd1;
        if (cnt_reg <= 2'd1) begin
          cnt_next   = 2'd0;
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_RUN;
        cnt_next   = 2'd0;
      end
    endcase
    // A taken branch squashes whatever ID and IF hold, stall included.
    if (ex_branch_taken) begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_next = ST_RUN;
      cnt_next   = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_RUN;
      cnt_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: stalls, forwarding, JR, branch override, reset.
module tb_hazard_unit;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       id_use_rs, id_use_rt, id_regwrite, id_memread, id_j, id_jr;
  logic       ex_branch_taken;
  logic       pc_write, ifid_write, ifid_flush, idex_flush;
  logic [1:0] fwd_a, fwd_b, fwd_jr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_unit #(.REG_AW(5), .FWD_W(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_dst         (id_dst),
    .id_use_rs      (id_use_rs),
    .id_use_rt      (id_use_rt),
    .id_regwrite    (id_regwrite),
    .id_memread     (id_memread),
    .id_j           (id_j),
    .id_jr          (id_jr),
    .ex_branch_taken(ex_branch_taken),
    .pc_write       (pc_write),
    .ifid_write     (ifid_write),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b),
    .fwd_jr         (fwd_jr)
  );

  // ctl = {pc_write, ifid_write, ifid_flush, idex_flush}
  logic [3:0] ctl;
  assign ctl = {pc_write, ifid_write, ifid_flush, idex_flush};

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                       input logic urs, input logic urt, input logic rw, input logic mr,
                       input logic j, input logic jr);
    id_rs = rs; id_rt = rt; id_dst = dst;
    id_use_rs = urs; id_use_rt = urt; id_regwrite = rw; id_memread = mr;
    id_j = j; id_jr = jr;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ex_branch_taken = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick(); tick();
    @(negedge clk);
    total++;
    if (ctl !== 4'b1100) begin bad++; $display("FAIL reset_ctl: got %b want %b", ctl, 4'b1100); end
    total++;
    if ({fwd_a, fwd_b, fwd_jr} !== 6'b0) begin
      bad++; $display("FAIL reset_fwd: got %b want %b", {fwd_a, fwd_b, fwd_jr}, 6'b0);
    end
    tick();
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    drive(5'd1, 5'd2, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);  // lw $2
    @(negedge clk);
    total++;
    if (ctl !== 4'b1100) begin bad++; $display("FAIL lu_lw_issue: got %b want %b", ctl, 4'b1100); end
    tick();
    drive(5'd2, 5'd4, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);  // add $3,$2,$4
    @(negedge clk);
    total++;
    if (ctl !== 4'b0001) begin bad++; $display("FAIL lu_stall: got %b want %b", ctl, 4'b0001); end
    tick();
    @(negedge clk);
    total++;
    if (ctl !== 4'b1100) begin bad++; $display("FAIL lu_release: got %b want %b", ctl, 4'b1100); end
    tick();
    idle();
    @(negedge clk);
    total++;
    if ({fwd_a, fwd_b} !== {FWD_WB, FWD_REG}) begin
      bad++; $display("FAIL lu_fwd: got %b want %b", {fwd_a, fwd_b}, {FWD_WB, FWD_REG});
    end
    drain();
    $display("test_load_use done");
  endtask

  task automatic test_forwarding();
    drive(5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();  // writes $6
    drive(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();  // writes $5
    drive(5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();  // add $7,$5,$6
    idle();
    @(negedge clk);
    total++;
    if ({fwd_a, fwd_b} !== {FWD_MEM, FWD_WB}) begin
      bad++; $display("FAIL fwd_mem_wb: got %b want %b", {fwd_a, fwd_b}, {FWD_MEM, FWD_WB});
    end
    drain();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    idle();
    @(negedge clk);
    total++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin
      bad++; $display("FAIL fwd_zero_dst: got %b want %b", {fwd_a, fwd_b}, 4'b0000);
    end
    drain();
    drive(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(5'd5, 5'd5, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    idle();
    @(negedge clk);
    total++;
    if ({fwd_a, fwd_b} !== {FWD_MEM, FWD_MEM}) begin
      bad++; $display("FAIL fwd_mem_priority: got %b want %b", {fwd_a, fwd_b}, {FWD_MEM, FWD_MEM});
    end
    drain();
    // Load in MEM never forwards from MEM; older WB writer of the same reg wins.
    drive(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    idle();
    @(negedge clk);
    total++;
    if (fwd_a !== FWD_WB) begin bad++; $display("FAIL fwd_mem_load: got %b want %b", fwd_a, FWD_WB); end
    drain();
    $display("test_forwarding done");
  endtask

  task automatic test_jr_load();
    drive(5'd29, 5'd31, 5'd31, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick();  // lw $31
    drive(5'd31, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);           // jr $31
    @(negedge clk);
    total++;
    if (ctl !== 4'b0001) begin bad++; $display("FAIL jrl_stall1: got %b want %b", ctl, 4'b0001); end
    tick();
    @(negedge clk);
    total++;
    if (ctl !== 4'b0001) begin bad++; $display("FAIL jrl_stall2: got %b want %b", ctl, 4'b0001); end
    tick();
    @(negedge clk);
    total++;
    if ({ctl, fwd_jr} !== {4'b1110, FWD_WB}) begin
      bad++; $display("FAIL jrl_release: got %b want %b", {ctl, fwd_jr}, {4'b1110, FWD_WB});
    end
    tick();
    idle();
    @(negedge clk);
    total++;
    if (ctl !== 4'b1100) begin bad++; $display("FAIL jrl_flush_once: got %b want %b", ctl, 4'b1100); end
    drain();
    $display("test_jr_load done");
  endtask

  task automatic test_jr_alu_and_mem_load();
    drive(5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();  // add $9
    drive(5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);          // jr $9
    @(negedge clk);
    total++;
    if (ctl !== 4'b0001) begin bad++; $display("FAIL jra_stall: got %b want %b", ctl, 4'b0001); end
    tick();
    @(negedge clk);
    total++;
    if ({ctl, fwd_jr} !== {4'b1110, FWD_MEM}) begin
      bad++; $display("FAIL jra_release: got %b want %b", {ctl, fwd_jr}, {4'b1110, FWD_MEM});
    end
    drain();
    drive(5'd1, 5'd10, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick();  // lw $10
    idle(); tick();
    drive(5'd10, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);           // jr $10
    @(negedge clk);
    total++;
    if (ctl !== 4'b0001) begin bad++; $display("FAIL jrm_stall: got %b want %b", ctl, 4'b0001); end
    tick();
    @(negedge clk);
    total++;
    if ({ctl, fwd_jr} !== {4'b1110, FWD_WB}) begin
      bad++; $display("FAIL jrm_release: got %b want %b", {ctl, fwd_jr}, {4'b1110, FWD_WB});
    end
    drain();
    $display("test_jr_alu_and_mem_load done");
  endtask

  task automatic test_jump();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    total++;
    if (ctl !== 4'b1110) begin bad++; $display("FAIL jump_flush: got %b want %b", ctl, 4'b1110); end
    drain();
    $display("test_jump done");
  endtask

  task automatic test_branch_override();
    drive(5'd1, 5'd2, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick();  // lw $2
    drive(5'd2, 5'd4, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);          // add uses $2
    ex_branch_taken = 1'b1;
    @(negedge clk);
    total++;
    if (ctl !== 4'b1111) begin bad++; $display("FAIL br_run_override: got %b want %b", ctl, 4'b1111); end
    tick();
    idle();
    @(negedge clk);
    total++;
    if ({dut.state_reg, ctl} !== {ST_RUN, 4'b1100}) begin
      bad++; $display("FAIL br_run_after: got %b want %b", {dut.state_reg, ctl}, {ST_RUN, 4'b1100});
    end
    drain();
    drive(5'd29, 5'd31, 5'd31, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick();  // lw $31
    drive(5'd31, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();    // jr $31, now STALL
    ex_branch_taken = 1'b1;
    @(negedge clk);
    total++;
    if ({dut.state_reg, ctl} !== {ST_STALL, 4'b1111}) begin
      bad++; $display("FAIL br_stall_override: got %b want %b", {dut.state_reg, ctl}, {ST_STALL, 4'b1111});
    end
    tick();
    idle();
    @(negedge clk);
    total++;
    if ({dut.state_reg, ctl} !== {ST_RUN, 4'b1100}) begin
      bad++; $display("FAIL br_stall_after: got %b want %b", {dut.state_reg, ctl}, {ST_RUN, 4'b1100});
    end
    drain();
    $display("test_branch_override done");
  endtask

  task automatic test_reset_mid_stall();
    drive(5'd29, 5'd31, 5'd31, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick();  // lw $31
    drive(5'd31, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();    // jr $31, now STALL
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (dut.state_reg !== ST_STALL) begin
      bad++; $display("FAIL rst_mid_pre: got %b want %b", dut.state_reg, ST_STALL);
    end
    tick();
    reset = 1'b0;
    // Reads $31: a surviving lw in WB would forward here.
    drive(5'd31, 5'd31, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if ({dut.state_reg, ctl, fwd_a, fwd_b, fwd_jr} !== {ST_RUN, 4'b1100, 6'b0}) begin
      bad++; $display("FAIL rst_mid_after: got %b want %b",
                      {dut.state_reg, ctl, fwd_a, fwd_b, fwd_jr}, {ST_RUN, 4'b1100, 6'b0});
    end
    drain();
    $display("test_reset_mid_stall done");
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #1;
    test_reset();
    test_load_use();
    test_forwarding();
    test_jr_load();
    test_jr_alu_and_mem_load();
    test_jump();
    test_branch_override();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
